sdes_fk_pipe: RTL and testbench
===============================

SDES_FK_PIPE -- requirements
Module: sdes_fk_pipe

Interface
REQ-001 Parameter: TAG_W, default 4, width of the user tag carried alongside each block.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  an input block is offered.
REQ-005 in_ready  output  1  the block accepts the offered input.
REQ-006 in_data  input  8  {L[7:4], R[3:0]}; bit 7 is SDES bit 1.
REQ-007 in_key  input  8  round subkey (K1 or K2).
REQ-008 in_tag  input  TAG_W  user tag.
REQ-009 in_swap  input  1  request SW half-swap on output.
REQ-010 s0_in, s1_in  output  4 each  lookup index to the external S0/S1 instances; bit order {r1,c1,c0,r0}.
REQ-011 s0_out, s1_out  input  2 each  combinational S-box results.
REQ-012 out_valid  output  1  a result is available.
REQ-013 out_ready  input  1  the consumer accepts the result.
REQ-014 out_data  output  8  fk result.
REQ-015 out_tag  output  TAG_W  tag of out_data.
REQ-016 blk_cnt  output  16  count of completed output handshakes; wraps from 0xFFFF to 0.

Function
REQ-017 A transfer SHALL occur on any clk edge where valid and ready are both 1.
REQ-018 Stage A SHALL register L, R, tag, swap, and x = EP(R) XOR key, where EP = R bits 4,1,2,3,2,3,4,1. It SHALL drive s0_in=x[7:4] and s1_in=x[3:0] from its registers only.
REQ-019 Stage B SHALL register: tag, and data = {L XOR P4, R}, where P4 = bits 2,4,3,1 of {s0_out,s1_out}. The SW rule of REQ-029 applies.
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to out_valid; throughput SHALL be one block per cycle.
REQ-021 Stage B SHALL load when it is empty or out_ready=1. Stage A SHALL advance into B under the same condition.
REQ-022 in_ready SHALL be 1 when stage A is empty or stage A advances in that cycle. It SHALL NOT depend on in_valid.
REQ-023 When both stages are full and out_ready=0, all registers SHALL hold and in_ready SHALL be 0.
REQ-024 out_data and out_tag SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous input transfer, A to B advance, and output transfer SHALL lose and duplicate no block.
REQ-026 blk_cnt SHALL increment by 1 on each output transfer.

Reset
REQ-027 While rst_n=0: out_valid=0, both stage-valid flags=0, blk_cnt=0, out_data=0, out_tag=0, s0_in=0, s1_in=0, in_ready=0.
REQ-028 Assertion of rst_n mid-operation SHALL discard every in-flight block. in_ready SHALL be 1 from the first edge after rst_n returns to 1.

Configuration
REQ-029 Macro SDES_FK_SWAP_EN:
- Defined: if in_swap=1, out_data SHALL be {R, L XOR P4}.
- Undefined: in_swap SHALL be ignored, no swap logic SHALL be present, and out_data SHALL always be {L XOR P4, R}.

Structure
REQ-030 A shared package sdes_pkg SHALL hold the EP, P4 and SW permutation index constants. It SHALL also hold a nibble_t/byte_t typedef and an EP function.
REQ-031 One sub-module, sdes_fk_stage_reg, SHALL be used twice. It is a valid/ready register slice with payload width as a parameter. The S-boxes SHALL stay outside this block.

Verification
REQ-032 S-box instances attached to the block SHALL be the team S0 and a standard S1.
- Stimulus: in_data=0x00, key=0x00.
- Response: s0_in=0x0 and s1_in=0x0 one cycle after transfer; out_data=0x80 two cycles after transfer.
REQ-033
- Stimulus: in_data=0x0F, key=0x00, in_swap=0.
- Response: s0_in=0xF, s1_in=0xF, out_data=0x7F.
- Stimulus: in_swap=1 with SDES_FK_SWAP_EN defined.
- Response: out_data=0xF7.
REQ-034
- Stimulus: 8 back-to-back blocks with tags 0..7, out_ready=1.
- Response: out_valid=1 for 8 consecutive cycles, tags appear in order, blk_cnt=8.
REQ-035
- Stimulus: out_ready=0 with 3 blocks offered.
- Response: 2 blocks accepted, in_ready=0, out_data stable.
- Stimulus: out_ready=1 afterwards.
- Response: 3 results emitted in order.
REQ-036
- Stimulus: rst_n pulsed low with 2 blocks in flight.
- Response: out_valid=0, blk_cnt=0, and no stale result emitted after release.
REQ-037
- Stimulus: blk_cnt preloaded near 0xFFFF by running 65535 transfers, then 2 more transfers.
- Response: blk_cnt reads 0x0001.

Source files
------------

// File: rtl/sdes_pkg.sv
// ---------------------------------------------------------------------------
// sdes_pkg
// Shared S-DES definitions for the fk round pipeline and its neighbours.
//
// Contents:
//   nibble_t / byte_t : 4-bit and 8-bit data types
//   EP_IDX            : expansion/permutation source positions (8 from 4)
//   P4_IDX            : P4 permutation source positions (4 from 4)
//   SW_IDX            : half-swap source positions (8 from 8)
//   ep(), p4(), sw()  : helpers that apply the permutations above
//
// Index constants use S-DES numbering: position 1 is the most significant
// bit of the source vector, so position n of a W-bit vector is bit [W-n].
// ---------------------------------------------------------------------------
package sdes_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [7:0] byte_t;

    localparam int EP_IDX [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
    localparam int P4_IDX [4] = '{2, 4, 3, 1};
    localparam int SW_IDX [8] = '{5, 6, 7, 8, 1, 2, 3, 4};

    // Expand the right half R into the 8-bit value that is XORed with the key.
    function automatic byte_t ep(input nibble_t r);
        byte_t res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = r[2'(4 - EP_IDX[i])];
        end
        return res;
    endfunction

    // Permute the concatenated S-box outputs {s0_out, s1_out}.
    function automatic nibble_t p4(input nibble_t s);
        nibble_t res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            res[2'(3 - i)] = s[2'(4 - P4_IDX[i])];
        end
        return res;
    endfunction

    // Exchange the two halves of a byte.
    function automatic byte_t sw(input byte_t b);
        byte_t res;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[3'(7 - i)] = b[3'(8 - SW_IDX[i])];
        end
        return res;
    endfunction

endpackage

// File: rtl/sdes_fk_stage_reg.sv
// ---------------------------------------------------------------------------
// sdes_fk_stage_reg
// One valid/ready register slice with a parameterised payload. Two of these
// form the fk pipeline; the slice itself knows nothing about S-DES.
//
// Parameters:
//   W          payload width
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears valid and payload)
//   in_valid   upstream offers a payload
//   in_ready   slice can take a payload this cycle
//   in_data    upstream payload
//   out_valid  slice holds a payload
//   out_ready  downstream takes the payload this cycle
//   out_data   held payload
// ---------------------------------------------------------------------------
module sdes_fk_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // The slice can refill whenever it is empty or its content leaves in the
    // same cycle, which gives full throughput without a skid buffer.
    assign in_ready = !valid_q || out_ready;

    // The payload is only written when a new block actually arrives, so the
    // output stays stable while stalled and also while the slice is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/sdes_fk_pipe.sv
// ---------------------------------------------------------------------------
// sdes_fk_pipe
// Two-stage pipelined S-DES round function fk with valid/ready handshakes.
// Stage A registers the halves, tag and EP(R) XOR key and presents the key
// mix to external S0/S1 lookups; stage B registers {L XOR P4, R} and the tag.
//
// Optional feature (compile-time macro SDES_FK_SWAP_EN):
//   defined   : in_swap = 1 makes out_data = {R, L XOR P4}
//   undefined : in_swap is ignored and no swap logic is built
//
// Parameters:
//   TAG_W      width of the user tag travelling with each block
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake
//   in_data              {L, R}, bit 7 is S-DES bit 1
//   in_key               round subkey
//   in_tag               user tag
//   in_swap              request output half swap
//   s0_in, s1_in         S-box lookup indices {r1, c1, c0, r0}
//   s0_out, s1_out       S-box results (combinational, external)
//   out_valid/out_ready  output handshake
//   out_data, out_tag    fk result and its tag
//   blk_cnt              completed output handshakes, wraps at 16 bits
// ---------------------------------------------------------------------------
module sdes_fk_pipe
    import sdes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [7:0]       in_key,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             in_swap,
    output logic [3:0]       s0_in,
    output logic [3:0]       s1_in,
    input  logic [1:0]       s0_out,
    input  logic [1:0]       s1_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [15:0]      blk_cnt
);

`ifdef SDES_FK_SWAP_EN
    localparam int SWAP_W = 1;
`else
    localparam int SWAP_W = 0;
`endif

    // Stage A payload: {tag, [swap,] L, R, x}, with x in the low byte.
    localparam int A_W = TAG_W + SWAP_W + 16;
    // Stage B payload: {tag, data}.
    localparam int B_W = TAG_W + 8;

    logic             run_q;
    logic             a_in_valid;
    logic             a_in_ready;
    logic             a_valid;
    logic             b_in_ready;
    logic             b_valid;
    logic [A_W-1:0]   a_in_pay;
    logic [A_W-1:0]   a_pay;
    logic [B_W-1:0]   b_in_pay;
    logic [B_W-1:0]   b_pay;
    nibble_t          a_l;
    nibble_t          a_r;
    nibble_t          f_mix;
    nibble_t          l_new;
    byte_t            a_x;
    byte_t            fk_data;
    logic [TAG_W-1:0] a_tag;
    logic [15:0]      cnt_q;

    // run_q keeps in_ready low during reset (when both stages are empty and
    // would otherwise report ready) and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign a_in_valid = in_valid && run_q;
    assign in_ready   = run_q && a_in_ready;

`ifdef SDES_FK_SWAP_EN
    assign a_in_pay = {in_tag, in_swap, in_data, ep(in_data[3:0]) ^ in_key};
`else
    logic unused_swap;
    assign unused_swap = in_swap;
    assign a_in_pay = {in_tag, in_data, ep(in_data[3:0]) ^ in_key};
`endif

    sdes_fk_stage_reg #(
        .W (A_W)
    ) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_pay),
        .out_valid (a_valid),
        .out_ready (b_in_ready),
        .out_data  (a_pay)
    );

    assign a_x   = a_pay[7:0];
    assign a_r   = a_pay[11:8];
    assign a_l   = a_pay[15:12];
    assign a_tag = a_pay[A_W-1 -: TAG_W];

    // The S-box indices come straight from stage A flops so the external
    // lookups see a clean registered path.
    assign s0_in = a_x[7:4];
    assign s1_in = a_x[3:0];

    assign f_mix = p4({s0_out, s1_out});
    assign l_new = a_l ^ f_mix;

`ifdef SDES_FK_SWAP_EN
    assign fk_data = a_pay[16] ? sw({l_new, a_r}) : {l_new, a_r};
`else
    assign fk_data = {l_new, a_r};
`endif

    assign b_in_pay = {a_tag, fk_data};

    sdes_fk_stage_reg #(
        .W (B_W)
    ) u_stage_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_pay),
        .out_valid (b_valid),
        .out_ready (out_ready),
        .out_data  (b_pay)
    );

    assign out_valid = b_valid;
    assign out_data  = b_pay[7:0];
    assign out_tag   = b_pay[B_W-1 -: TAG_W];

    // Completed output handshakes; the 16-bit counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (b_valid && out_ready) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign blk_cnt = cnt_q;

endmodule

// File: tb/tb_sdes_fk_pipe.sv
// ---------------------------------------------------------------------------
// tb_sdes_fk_pipe
// Self-checking bench for sdes_fk_pipe. Provides the S0/S1 lookups, a table
// of single-block vectors, multi-cycle sequences (back-to-back, stall,
// mid-flight reset, counter wrap) and randomized traffic checked against a
// scoreboard fed by a behavioural fk model.
// ---------------------------------------------------------------------------
module tb_sdes_fk_pipe;

    localparam int TAG_W = 4;

`ifdef SDES_FK_SWAP_EN
    localparam bit SWAP_EN = 1'b1;
`else
    localparam bit SWAP_EN = 1'b0;
`endif

    localparam int S0_TAB [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
    localparam int S1_TAB [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [7:0]       in_key;
    logic [TAG_W-1:0] in_tag;
    logic             in_swap;
    logic [3:0]       s0_in;
    logic [3:0]       s1_in;
    logic [1:0]       s0_out;
    logic [1:0]       s1_out;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      blk_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sdes_fk_pipe #(
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_tag    (in_tag),
        .in_swap   (in_swap),
        .s0_in     (s0_in),
        .s1_in     (s1_in),
        .s0_out    (s0_out),
        .s1_out    (s1_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .blk_cnt   (blk_cnt)
    );

    // External S-box instances: row = {r1, r0}, column = {c1, c0}.
    assign s0_out = 2'(S0_TAB[{s0_in[3], s0_in[0]}][s0_in[2:1]]);
    assign s1_out = 2'(S1_TAB[{s1_in[3], s1_in[0]}][s1_in[2:1]]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model (S-DES bit numbering) -------------
    function automatic int fk_x(input int d, input int k);
        int ep_pos [8] = '{4, 1, 2, 3, 2, 3, 4, 1};
        int rv;
        int x;
        rv = d & 15;
        x  = 0;
        for (int i = 0; i < 8; i++) x = (x << 1) | ((rv >> (4 - ep_pos[i])) & 1);
        return (x ^ k) & 255;
    endfunction

    function automatic logic [7:0] fk_model(input int d, input int k, input bit swp);
        int p4_pos [4] = '{2, 4, 3, 1};
        int x, sb, p, lnew, rv, res;
        x  = fk_x(d, k);
        sb = S0_TAB[((x >> 7) & 1) * 2 + ((x >> 4) & 1)][(x >> 5) & 3] * 4
           + S1_TAB[((x >> 3) & 1) * 2 + (x & 1)][(x >> 1) & 3];
        p = 0;
        for (int i = 0; i < 4; i++) p = (p << 1) | ((sb >> (4 - p4_pos[i])) & 1);
        lnew = ((d >> 4) & 15) ^ p;
        rv   = d & 15;
        res  = (SWAP_EN && swp) ? (rv * 16 + lnew) : (lnew * 16 + rv);
        return 8'(res);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic [7:0] k,
                                 input logic [TAG_W-1:0] t, input logic s);
        in_data  = d;
        in_key   = k;
        in_tag   = t;
        in_swap  = s;
        in_valid = 1'b1;
    endtask

    // ---------------- scoreboard monitor -----------------------------------
    // Sampled on the falling edge: a handshake seen here happens at the next
    // rising edge.
    logic [TAG_W+7:0] sb_q [$];
    logic [15:0]      exp_cnt;
    bit               hold_prev;
    logic [TAG_W+7:0] hold_val;

    initial begin
        exp_cnt   = '0;
        hold_prev = 1'b0;
        hold_val  = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("blk_cnt_track", 32'(blk_cnt), 32'(exp_cnt));
            if (hold_prev) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                checkOutput("stall_stable", 32'({out_tag, out_data}), 32'(hold_val));
            end
            hold_prev = out_valid && !out_ready;
            hold_val  = {out_tag, out_data};
            if (out_valid && out_ready) begin
                exp_cnt = exp_cnt + 16'd1;
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("sb_data", 32'(out_data), 32'(sb_q[0][7:0]));
                    checkOutput("sb_tag", 32'(out_tag), 32'(sb_q[0][TAG_W+7:8]));
                    void'(sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back({in_tag, fk_model(int'(in_data), int'(in_key), in_swap)});
            end
        end
    end

    // Reset pulse with reset-state checks; also clears the scoreboard.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        exp_cnt   = '0;
        hold_prev = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_tag", 32'(out_tag), 32'd0);
        checkOutput("rst_s0_in", 32'(s0_in), 32'd0);
        checkOutput("rst_s1_in", 32'(s1_in), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready_after_release", 32'(in_ready), 32'd1);
    endtask

    // ---------------- vector table -----------------------------------------
    typedef struct {
        logic [7:0]       data;
        logic [7:0]       key;
        logic [TAG_W-1:0] tag;
        logic             swap;
        logic [3:0]       exp_s0;
        logic [3:0]       exp_s1;
        logic [7:0]       exp_out;
    } vec_t;

    vec_t vecs [7];

    logic [7:0] bp_exp [3];
    int         bp_got;

    task automatic sample_bp();
        if (out_valid && out_ready) begin
            if (bp_got < 3) checkOutput("bp_order", 32'(out_data), 32'(bp_exp[bp_got]));
            bp_got++;
        end
    endtask

    // Watchdog: every wait below is bounded, this only guards against a hang.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d, k;
        int run, max_run, idx, acc, ok_cnt;
        bit took;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0;
        in_tag = '0; in_swap = 1'b0; out_ready = 1'b1;

        $display("[TB] reset");
        pulse_reset();

        // Fixed vectors plus random ones evaluated by the model.
        vecs[0] = '{8'h00, 8'h00, 4'h1, 1'b0, 4'h0, 4'h0, 8'h80};
        vecs[1] = '{8'h0F, 8'h00, 4'h2, 1'b0, 4'hF, 4'hF, 8'h7F};
        vecs[2] = '{8'h0F, 8'h00, 4'h3, 1'b1, 4'hF, 4'hF, SWAP_EN ? 8'hF7 : 8'h7F};
        for (int i = 3; i < 7; i++) begin
            d = 8'($urandom_range(0, 255));
            k = 8'($urandom_range(0, 255));
            vecs[i].data    = d;
            vecs[i].key     = k;
            vecs[i].tag     = TAG_W'(i);
            vecs[i].swap    = 1'($urandom_range(0, 1));
            vecs[i].exp_s0  = 4'(fk_x(int'(d), int'(k)) >> 4);
            vecs[i].exp_s1  = 4'(fk_x(int'(d), int'(k)) & 15);
            vecs[i].exp_out = fk_model(int'(d), int'(k), vecs[i].swap);
        end

        $display("[TB] vector table");
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].data, vecs[i].key, vecs[i].tag, vecs[i].swap);
            @(negedge clk);
            checkOutput("tbl_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            checkOutput("tbl_s0_in", 32'(s0_in), 32'(vecs[i].exp_s0));
            checkOutput("tbl_s1_in", 32'(s1_in), 32'(vecs[i].exp_s1));
            @(negedge clk);
            checkOutput("tbl_out_valid", 32'(out_valid), 32'd1);
            checkOutput("tbl_out_data", 32'(out_data), 32'(vecs[i].exp_out));
            checkOutput("tbl_out_tag", 32'(out_tag), 32'(vecs[i].tag));
            @(negedge clk);
            checkOutput("tbl_drained", 32'(out_valid), 32'd0);
        end

        $display("[TB] back-to-back");
        pulse_reset();
        run = 0; max_run = 0; idx = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c < 8) applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), TAG_W'(c), 1'b0);
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (run > max_run) max_run = run;
                if (idx < 8) checkOutput("b2b_tag_order", 32'(out_tag), 32'(idx));
                idx++;
            end else begin
                run = 0;
            end
        end
        checkOutput("b2b_consecutive", 32'(max_run), 32'd8);
        checkOutput("b2b_count", 32'(idx), 32'd8);
        checkOutput("b2b_blk_cnt", 32'(blk_cnt), 32'd8);

        $display("[TB] backpressure");
        acc = 0; bp_got = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            d = 8'($urandom_range(0, 255));
            k = 8'($urandom_range(0, 255));
            bp_exp[b] = fk_model(int'(d), int'(k), 1'b0);
            applyStimulus(d, k, TAG_W'(b + 9), 1'b0);
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            if (b < 2) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_hold_data", 32'(out_data), 32'(bp_exp[0]));
        end
        checkOutput("bp_accepted", 32'(acc), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_resume_ready", 32'(in_ready), 32'd1);
        sample_bp();
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            sample_bp();
        end
        checkOutput("bp_emitted", 32'(bp_got), 32'd3);

        $display("[TB] reset with blocks in flight");
        @(posedge clk); #1;
        applyStimulus(8'h5A, 8'hC3, 4'hA, 1'b0);
        @(posedge clk); #1;
        applyStimulus(8'hA5, 8'h3C, 4'hB, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2;
        pulse_reset();
        run = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) run++;
        end
        checkOutput("no_stale_output", 32'(run), 32'd0);

        $display("[TB] randomized traffic");
        took = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = 8'($urandom_range(0, 255));
                in_key   = 8'($urandom_range(0, 255));
                in_tag   = TAG_W'($urandom_range(0, 15));
                in_swap  = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ok_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !out_valid) ok_cnt++;
        end
        checkOutput("random_drained", 32'(ok_cnt > 0), 32'd1);
        checkOutput("random_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] counter wrap");
        pulse_reset();
        @(posedge clk); #1;
        applyStimulus(8'h12, 8'h34, 4'h0, 1'b0);
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk); #1;
            if (i == 65536) in_valid = 1'b0;
            else applyStimulus(8'(i), 8'(i >> 8), TAG_W'(i), 1'b0);
        end
        repeat (4) @(negedge clk);
        checkOutput("wrap_blk_cnt", 32'(blk_cnt), 32'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
